// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt request front-end.
package irq_pkg;

    localparam int unsigned IRQ_N_SRC_MAX  = 32;
    localparam int unsigned DEBOUNCE_CNT_W = 8;

    typedef logic [IRQ_N_SRC_MAX-1:0] irq_vec_t;

    typedef enum logic {
        IRQ_MODE_LEVEL = 1'b0,
        IRQ_MODE_EDGE  = 1'b1
    } irq_mode_e;

    function automatic logic irq_is_edge(input logic mode);
        return mode == IRQ_MODE_EDGE;
    endfunction

    // Terminal count of the debounce counter for a given stable-cycle requirement.
    function automatic logic [DEBOUNCE_CNT_W-1:0] irq_db_last(input int unsigned cycles);
        return DEBOUNCE_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/irq_sync_cell.sv
// Per-source synchroniser with optional debounce filter (IRQ_DEBOUNCE_EN).
// Output d_o is the value the pending/edge logic acts on.
module irq_sync_cell
    import irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2
`ifdef IRQ_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic irq_i,
    output logic d_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef IRQ_DEBOUNCE_EN
    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = irq_db_last(DEBOUNCE_CYCLES);

    logic [DEBOUNCE_CNT_W-1:0] cnt_q, cnt_d;
    logic                      db_q, db_d;

    // A change is accepted only after s has disagreed with db for DEBOUNCE_CYCLES samples.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (s != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = s;
            end else begin
                cnt_d = cnt_q + DEBOUNCE_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign d_o = db_q;
`else
    assign d_o = s;
`endif

endmodule

// File: rtl/irq_request_latch.sv
// Interrupt request front-end: synchronises peripheral lines and presents edge-latched
// or level requests to the controller. Optional debounce via IRQ_DEBOUNCE_EN.
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC           = 32,
    parameter int unsigned SYNC_STAGES     = 2
`ifdef IRQ_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] irq_i,
    input  logic [N_SRC-1:0] edge_mode_i,
    input  logic [N_SRC-1:0] int_fin_i,
    input  logic             ovf_clr_i,
    output logic [N_SRC-1:0] int_req_o,
    output logic [N_SRC-1:0] ovf_o,
    output logic             int_any_o
);

    logic [N_SRC-1:0] d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] ovf_q, ovf_d;
    logic             int_any_q;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_sync_cell #(
            .SYNC_STAGES     (SYNC_STAGES)
`ifdef IRQ_DEBOUNCE_EN
            ,
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
        ) u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .irq_i  (irq_i[i]),
            .d_o    (d[i])
        );
    end

    // prev always tracks d, so a level->edge switch never fabricates a rise.
    assign rise = d & ~prev_q;

    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_clr_i ? '0 : ovf_q;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (irq_is_edge(edge_mode_i[i])) begin
                if (rise[i]) begin
                    pending_d[i] = 1'b1;
                    if (pending_q[i] && !int_fin_i[i]) begin
                        ovf_d[i] = 1'b1;
                    end
                end else if (int_fin_i[i]) begin
                    pending_d[i] = 1'b0;
                end
            end else begin
                pending_d[i] = d[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q    <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            int_any_q <= 1'b0;
        end else begin
            prev_q    <= d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            int_any_q <= |pending_d;
        end
    end

    assign int_req_o = pending_q;
    assign ovf_o     = ovf_q;
    assign int_any_o = int_any_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Bench for irq_request_latch: queue-based reference model checked every cycle plus
// directed literal expectations. Covers the IRQ_DEBOUNCE_EN build when defined.
module tb_irq_request_latch;

    localparam int unsigned SYNC = 2;
`ifdef IRQ_DEBOUNCE_EN
    localparam int unsigned DB  = 4;
    localparam int unsigned PW  = DB;
    localparam int unsigned LAT = SYNC + DB + 1;
`else
    localparam int unsigned PW  = 1;
    localparam int unsigned LAT = SYNC + 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] irq, mode, fin;
    logic        clr;
    logic [31:0] req, ovf;
    logic        any;

    irq_request_latch #(
        .N_SRC           (32),
        .SYNC_STAGES     (SYNC)
`ifdef IRQ_DEBOUNCE_EN
        ,
        .DEBOUNCE_CYCLES (DB)
`endif
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .irq_i       (irq),
        .edge_mode_i (mode),
        .int_fin_i   (fin),
        .ovf_clr_i   (clr),
        .int_req_o   (req),
        .ovf_o       (ovf),
        .int_any_o   (any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: s is irq as sampled SYNC edges ago (delay queue).
    logic [31:0] m_hist[$];
    logic [31:0] m_prev, m_pend, m_ovf;
    logic        m_any;
`ifdef IRQ_DEBOUNCE_EN
    logic [31:0]  m_d;
    int unsigned  m_run[32];
`endif

    task automatic m_reset();
        m_hist = {};
        for (int k = 0; k < int'(SYNC); k++) m_hist.push_back(32'h0);
        m_prev = '0;
        m_pend = '0;
        m_ovf  = '0;
        m_any  = 1'b0;
`ifdef IRQ_DEBOUNCE_EN
        m_d = '0;
        for (int k = 0; k < 32; k++) m_run[k] = 0;
`endif
    endtask

    task automatic m_step();
        logic [31:0] s, dv, set_ovf;
        s = m_hist.pop_front();
        m_hist.push_back(irq);
`ifdef IRQ_DEBOUNCE_EN
        dv = m_d;
        for (int k = 0; k < 32; k++) begin
            if (s[k] != m_d[k]) begin
                m_run[k]++;
                if (m_run[k] == DB) begin
                    m_d[k]   = s[k];
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
`else
        dv = s;
`endif
        set_ovf = '0;
        for (int k = 0; k < 32; k++) begin
            if (mode[k]) begin
                if (dv[k] && !m_prev[k]) begin
                    if (m_pend[k] && !fin[k]) set_ovf[k] = 1'b1;
                    m_pend[k] = 1'b1;
                end else if (fin[k]) begin
                    m_pend[k] = 1'b0;
                end
            end else begin
                m_pend[k] = dv[k];
            end
        end
        m_ovf  = (clr ? 32'h0 : m_ovf) | set_ovf;
        m_prev = dv;
        m_any  = |m_pend;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_req", req, m_pend);
            chk("model_ovf", ovf, m_ovf);
            chk("model_any", 32'(any), 32'(m_any));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [31:0] v);
        irq = v;
        cyc(PW);
        irq = '0;
    endtask

    typedef struct packed {
        logic [31:0] irq;
        logic [31:0] mode;
        logic [31:0] fin;
        logic        clr;
    } vec_t;

    localparam vec_t TBL [10] = '{
        '{32'h0000_00FF, 32'h0000_000F, 32'h0, 1'b0},
        '{32'h0000_0000, 32'h0000_000F, 32'h0, 1'b0},
        '{32'h0000_0003, 32'h0000_000F, 32'h1, 1'b0},
        '{32'h0000_0000, 32'h0000_000F, 32'h0, 1'b0},
        '{32'h0000_0001, 32'h0000_000F, 32'h0, 1'b0},
        '{32'h0000_0000, 32'h0000_000F, 32'h2, 1'b1},
        '{32'h0000_00F0, 32'h0000_00F0, 32'h0, 1'b0},
        '{32'h0000_0000, 32'h0000_000F, 32'h4, 1'b0},
        '{32'h0000_0000, 32'h0000_000F, 32'h8, 1'b0},
        '{32'h0000_0000, 32'h0000_000F, 32'h0, 1'b1}
    };

    initial begin
        rst_n = 1'b0;
        irq   = 32'hFFFF_FFFF;
        mode  = '0;
        fin   = '0;
        clr   = 1'b0;
        cyc(2);
        chk("rst_req", req, 32'h0);
        chk("rst_ovf", ovf, 32'h0);
        chk("rst_any", 32'(any), 32'h0);

        // Release with all level lines high
        rst_n = 1'b1;
        cyc(LAT - 1);
        chk("rel_req_early", req, 32'h0);
        cyc(1);
        chk("rel_req", req, 32'hFFFF_FFFF);
        chk("rel_any", 32'(any), 32'h1);
        irq = '0;
        cyc(LAT + 2);
        chk("level_drain", req, 32'h0);

        // Edge latch on source 5
        mode = '1;
        cyc(1);
        pulse(32'h20);
        cyc(LAT - PW - 1);
        chk("edge5_early", req, 32'h0);
        cyc(1);
        chk("edge5_set", req, 32'h20);
        cyc(4);
        chk("edge5_hold", req, 32'h20);
        fin = 32'h20;
        cyc(1);
        fin = '0;
        chk("edge5_fin", req, 32'h0);

        // Overflow on source 5
        cyc(LAT + 2);
        pulse(32'h20);
        cyc(LAT - PW);
        chk("ovf_first", req, 32'h20);
        cyc(LAT);
        pulse(32'h20);
        cyc(LAT - PW);
        chk("ovf_set", ovf, 32'h20);
        chk("ovf_req", req, 32'h20);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("ovf_clr", ovf, 32'h0);
        chk("ovf_clr_req", req, 32'h20);
        fin = 32'h20;
        cyc(1);
        fin = '0;
        chk("ovf_fin", req, 32'h0);

        // Rise and completion in the same cycle on source 3
        cyc(LAT + 2);
        pulse(32'h08);
        cyc(LAT - PW);
        chk("simul_first", req, 32'h08);
        cyc(LAT);
        irq = 32'h08;
        cyc(PW);
        irq = '0;
        cyc(LAT - PW - 1);
        fin = 32'h08;
        cyc(1);
        fin = '0;
        chk("simul_req", req, 32'h08);
        chk("simul_ovf", ovf, 32'h0);
        fin = 32'h08;
        cyc(1);
        fin = '0;
        chk("simul_clear", req, 32'h0);
        fin = 32'h08;
        cyc(1);
        fin = '0;
        chk("fin_idle", req, 32'h0);

        // Level mode on source 0 with ignored completions
        cyc(LAT + 2);
        mode = '0;
        irq  = 32'h1;
        for (int k = 0; k < 10; k++) begin
            fin = (k % 2 == 1) ? 32'h1 : 32'h0;
            cyc(1);
        end
        fin = '0;
        chk("lvl_held", req, 32'h1);
        irq = '0;
        cyc(LAT - 1);
        chk("lvl_fall_early", req, 32'h1);
        cyc(1);
        chk("lvl_fall", req, 32'h0);

        // Several pending plus an overflow, then async reset between edges
        mode = '1;
        cyc(LAT + 2);
        pulse(32'h0000_0F0F);
        cyc(LAT - PW);
        chk("multi_set", req, 32'h0000_0F0F);
        cyc(LAT);
        pulse(32'h1);
        cyc(LAT - PW);
        chk("multi_ovf", ovf, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", req, 32'h0);
        chk("async_ovf", ovf, 32'h0);
        chk("async_any", 32'(any), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(LAT + 2);
        chk("post_async", req, 32'h0);

        // Mixed-mode vector table
        for (int k = 0; k < 10; k++) begin
            irq  = TBL[k].irq;
            mode = TBL[k].mode;
            fin  = TBL[k].fin;
            clr  = TBL[k].clr;
            cyc(1);
        end
        irq = '0;
        fin = '0;
        clr = 1'b0;
        cyc(LAT + 2);

`ifdef IRQ_DEBOUNCE_EN
        mode = '1;
        fin  = 32'h80;
        cyc(1);
        fin  = '0;
        irq  = 32'h80;
        cyc(2);
        irq = '0;
        cyc(12);
        chk("db_glitch", req & 32'h80, 32'h0);
        irq = 32'h80;
        cyc(6);
        irq = '0;
        chk("db_early", req & 32'h80, 32'h0);
        cyc(1);
        chk("db_set", req & 32'h80, 32'h80);
        cyc(LAT + 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Front-end stage directly upstream of the interrupt controller.
- Synchronises asynchronous peripheral interrupt lines into the core clock domain and converts each one into a stable int_req bit.
- Per source, the line is treated as edge-triggered (latched pending) or level-sensitive.
- Drives the controller's int_req input and consumes its one-hot int_fin completion vector to retire pending edge requests.

Parameters:
- N_SRC, 32, number of interrupt sources (1..32).
- SYNC_STAGES, 2, depth of the per-source synchroniser chain (>=2).
- DEBOUNCE_CYCLES, 4, stable cycles required before a change is accepted (used only with IRQ_DEBOUNCE_EN; 1..255).

Ports:
- clk_i  input  1  core clock; everything is single clock domain.
- rst_ni  input  1  asynchronous, active-low reset.
- irq_i  input  N_SRC  raw peripheral interrupt lines, asynchronous to clk_i.
- edge_mode_i  input  N_SRC  per-source mode: 1 = rising-edge latched, 0 = level.
- int_fin_i  input  N_SRC  completion vector from the interrupt controller, at most one bit high per cycle.
- ovf_clr_i  input  1  single-cycle pulse that clears all overflow flags.
- int_req_o  output  N_SRC  request vector to the interrupt controller, registered.
- ovf_o  output  N_SRC  sticky per-source flag: an edge was lost.
- int_any_o  output  1  OR of int_req_o, registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_ni low, asynchronous): clears all synchroniser flops, prev, pending, ovf_o, int_req_o and int_any_o to 0. Deassertion takes effect at the next clk_i edge.
- Synchroniser:
  - irq_i[i] passes through SYNC_STAGES flops to give s[i].
  - prev[i] <= s[i] every cycle.
  - rise[i] = s[i] & ~prev[i].
- Edge mode (edge_mode_i[i]=1):
  - pending[i] sets on rise[i] and clears on int_fin_i[i].
  - rise and int_fin in the same cycle: pending stays 1 (new event wins); ovf unchanged.
  - rise while pending=1 and no int_fin: pending stays 1; ovf_o[i] <= 1.
  - int_fin with pending=0: no effect.
- Level mode (edge_mode_i[i]=0):
  - pending[i] <= s[i] every cycle; int_fin_i[i] is ignored; ovf never sets.
- Mode switch: takes effect on the next cycle.
  - Edge -> level: pending is overwritten by s.
  - Level -> edge: pending keeps its current value. prev is always tracking, so no spurious rise is generated.
- Outputs:
  - int_req_o = pending (registered).
  - int_any_o <= |pending_next, so it is aligned with int_req_o.
- Latency: irq_i rising to int_req_o high takes SYNC_STAGES+1 clk_i edges. int_fin_i to int_req_o low takes 1 edge.
- Overflow clear: ovf_clr_i clears all ovf_o the next cycle. A simultaneous overflow event takes priority and leaves that bit at 1.
- Bits >= N_SRC do not exist; the block does no width extension.

Optional Feature:
- Macro: IRQ_DEBOUNCE_EN.
- With the macro defined:
  - Each source has an 8-bit counter and a debounced value d[i], inserted between s[i] and the edge/level logic.
  - The counter resets to 0 whenever s[i] == d[i].
  - Otherwise it increments each cycle; when it reaches DEBOUNCE_CYCLES-1, d[i] <= s[i] and the counter clears.
  - prev tracks d, and latency grows by DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are dropped.
  - d and the counters reset to 0.
- Without the macro: d = s, no counters are synthesised, and latency is exactly SYNC_STAGES+1.

Decomposition:
- Package irq_pkg:
  - IRQ_N_SRC_MAX = 32.
  - typedef irq_vec_t = logic [31:0].
  - Mode constants IRQ_MODE_LEVEL = 1'b0 and IRQ_MODE_EDGE = 1'b1.
  - DEBOUNCE_CNT_W = 8.
- Sub-module irq_sync_cell, one instance per source via generate: synchroniser chain plus optional debounce counter, output d.
- Pending, overflow and output logic stay in the top module.

Test Plan:
- Reset: hold rst_ni=0, drive irq_i=32'hFFFF_FFFF -> int_req_o=0, ovf_o=0, int_any_o=0. Release reset -> level sources rise 3 cycles later (SYNC_STAGES=2).
- Edge latch: edge_mode_i=all 1, pulse irq_i[5] for 1 cycle held across one clk_i edge -> int_req_o=32'h20 after 3 cycles and held. int_fin_i=32'h20 for 1 cycle -> int_req_o=0 the next cycle.
- Overflow: with pending[5]=1, pulse irq_i[5] again and no int_fin -> ovf_o[5]=1 and int_req_o[5] stays 1. ovf_clr_i pulse -> ovf_o=0.
- Simultaneous: align a rise on source 3 with int_fin_i=32'h8 in the same cycle -> int_req_o[3] stays 1 and ovf_o[3]=0.
- Level mode: edge_mode_i=0, irq_i[0]=1 for 10 cycles -> int_req_o[0]=1 for 10 cycles delayed by 3. int_fin_i[0] pulses are ignored. Drop irq_i[0] -> int_req_o[0]=0 3 cycles later.
- Async reset mid-operation: assert rst_ni low between clock edges while several bits are pending -> all outputs 0 immediately, with no clk_i edge required.
- IRQ_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 2-cycle glitch -> no int_req. 6-cycle pulse -> int_req_o set 3+4 cycles after the edge.
